// File: rtl/dac_serializer_if.sv
// Sample capture and DAC pin bundle shared by the serializer and its driver.
// The slave side is the serializer; the master side supplies samples and watches the pins.
interface dac_serializer_if #(
  parameter int DATA_W = 12
);
  logic              Hlt;
  logic              Sample_stb;
  logic [DATA_W-1:0] Sample_data;
  logic              Dac_cs_n;
  logic              Dac_sclk;
  logic              Dac_sdi;
  logic              Dac_ldac_n;
  logic              Busy;
  logic              Overrun;
  logic [7:0]        Drop_cnt;

  modport master (
    output Hlt, Sample_stb, Sample_data,
    input  Dac_cs_n, Dac_sclk, Dac_sdi, Dac_ldac_n, Busy, Overrun, Drop_cnt
  );

  modport slave (
    input  Hlt, Sample_stb, Sample_data,
    output Dac_cs_n, Dac_sclk, Dac_sdi, Dac_ldac_n, Busy, Overrun, Drop_cnt
  );
endinterface

// File: rtl/dac_serializer.sv
// Captures filtered samples and shifts them out as {CFG_BITS, offset-binary} SPI frames, then pulses LDAC.
// Latency: chip select drops 1 cycle after an accepted strobe; a frame takes 35*CLK_DIV cycles.
// Backpressure: none upstream; one holding slot, further strobes are dropped and counted.
module dac_serializer #(
  parameter int               DATA_W   = 12,
  parameter int               CFG_W    = 4,
  parameter logic [CFG_W-1:0] CFG_BITS = 4'b0111,
  parameter int               CLK_DIV  = 4
) (
  input logic             Clk,
  input logic             Rst_n,
  dac_serializer_if.slave bus
);
  localparam int FRAME_W = CFG_W + DATA_W;
  localparam int HP_N    = 2 * FRAME_W;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HP_W    = $clog2(HP_N);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HP_W-1:0]   HP_LAST   = HP_W'(HP_N - 1);
  localparam logic [DATA_W-1:0] SIGN_FLIP = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_LDAC
  } state_e;

  state_e             state_q;
  logic [DIV_W-1:0]   div_q;
  logic [HP_W-1:0]    hp_q;
  logic [FRAME_W-1:0] sr_q;
  logic               cs_n_q;
  logic               sclk_q;
  logic               sdi_q;
  logic               ldac_n_q;
  logic               busy_q;

  logic               buf_vld_q, buf_vld_d;
  logic [DATA_W-1:0]  buf_dat_q, buf_dat_d;
  logic               ovr_q, ovr_d;
  logic [7:0]         drop_q, drop_d;

  logic               half_end;
  logic               accept;
  logic               load_slot;
  logic               load;
  logic [DATA_W-1:0]  load_dat;
  logic [FRAME_W-1:0] frame_d;

  always_comb begin
    half_end  = (div_q == DIV_LAST);
    accept    = bus.Sample_stb & ~bus.Hlt;
    load_slot = (state_q == S_IDLE) || ((state_q == S_LDAC) && half_end);
    load      = load_slot && (buf_vld_q || accept);
    load_dat  = buf_vld_q ? buf_dat_q : bus.Sample_data;
    frame_d   = {CFG_BITS, load_dat ^ SIGN_FLIP};

    buf_vld_d = buf_vld_q;
    buf_dat_d = buf_dat_q;
    ovr_d     = 1'b0;
    if (load) begin
      buf_vld_d = 1'b0;
    end
    // An empty slot being loaded takes the strobe straight into the shifter.
    if (accept && !(load && !buf_vld_q)) begin
      if (buf_vld_q && !load) begin
        ovr_d = 1'b1;
      end else begin
        buf_vld_d = 1'b1;
        buf_dat_d = bus.Sample_data;
      end
    end

    drop_d = drop_q;
    if (ovr_d && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      buf_vld_q <= 1'b0;
      buf_dat_q <= '0;
      ovr_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      buf_vld_q <= buf_vld_d;
      buf_dat_q <= buf_dat_d;
      ovr_q     <= ovr_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      hp_q     <= '0;
      sr_q     <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      sdi_q    <= 1'b0;
      ldac_n_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      div_q <= ((state_q == S_IDLE) || half_end) ? '0 : div_q + DIV_W'(1);
      case (state_q)
        S_IDLE: begin
          if (load) begin
            state_q <= S_SETUP;
            sr_q    <= frame_d;
            sdi_q   <= frame_d[FRAME_W-1];
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_SETUP: begin
          if (half_end) begin
            state_q <= S_SHIFT;
            hp_q    <= '0;
          end
        end
        S_SHIFT: begin
          if (half_end) begin
            sclk_q <= ~sclk_q;
            hp_q   <= hp_q + HP_W'(1);
            if (hp_q == HP_LAST) begin
              state_q <= S_HOLD;
              cs_n_q  <= 1'b1;
              sdi_q   <= 1'b0;
            end else if (hp_q[0]) begin
              // Odd half-periods end on a falling edge: present the next bit.
              sr_q  <= sr_q << 1;
              sdi_q <= sr_q[FRAME_W-2];
            end
          end
        end
        S_HOLD: begin
          if (half_end) begin
            state_q  <= S_LDAC;
            ldac_n_q <= 1'b0;
          end
        end
        S_LDAC: begin
          if (half_end) begin
            ldac_n_q <= 1'b1;
            if (load) begin
              state_q <= S_SETUP;
              sr_q    <= frame_d;
              sdi_q   <= frame_d[FRAME_W-1];
              cs_n_q  <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Dac_cs_n   = cs_n_q;
  assign bus.Dac_sclk   = sclk_q;
  assign bus.Dac_sdi    = sdi_q;
  assign bus.Dac_ldac_n = ldac_n_q;
  assign bus.Busy       = busy_q;
  assign bus.Overrun    = ovr_q;
  assign bus.Drop_cnt   = drop_q;
endmodule

// File: tb/tb_dac_serializer.sv
// Scoreboard bench for dac_serializer: CLK_DIV=4 main instance plus a CLK_DIV=1 smoke instance.
`timescale 1ns/1ps
module tb_dac_serializer;
  localparam int DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dac_serializer_if #(.DATA_W(12)) a_if ();
  dac_serializer_if #(.DATA_W(12)) b_if ();

  dac_serializer #(.DATA_W(12), .CFG_W(4), .CFG_BITS(4'b0111), .CLK_DIV(DIV)) u_dut (
    .Clk(clk), .Rst_n(rst_n), .bus(a_if.slave)
  );
  dac_serializer #(.DATA_W(12), .CFG_W(4), .CFG_BITS(4'b0111), .CLK_DIV(1)) u_dut1 (
    .Clk(clk), .Rst_n(rst_n), .bus(b_if.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  logic [15:0] sb_a[$];
  logic [15:0] sb_b[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] frame_of(input logic [11:0] d);
    return {4'b0111, d ^ 12'h800};
  endfunction

  always @(posedge clk) cyc++;

  // Monitor, CLK_DIV=4 instance
  logic [15:0] shr_a = '0;
  logic p_sclk_a = 1'b0, p_cs_a = 1'b1, p_ldac_a = 1'b1, p_sdi_a = 1'b0;
  int bits_a = 0, cs_low_a = 0, ldac_low_a = 0, cs_falls_a = 0;
  int csfall_cyc_a = 0, rise1_cyc_a = 0, ldacrise_cyc_a = 0, gap_a = -1;
  int ldac_pulses_a = 0, ovr_pulses_a = 0, ovr_cyc_a = 0, sdi_viol_a = 0;

  always @(negedge clk) begin
    if (!a_if.Dac_ldac_n) ldac_low_a++;
    if (a_if.Dac_ldac_n && !p_ldac_a) begin
      ldac_pulses_a++;
      ldacrise_cyc_a = cyc;
      if (mon_en) begin
        chk("a_ldac_width", ldac_low_a, DIV);
        chk("a_frame_latency", cyc - csfall_cyc_a, 35 * DIV);
      end
      ldac_low_a = 0;
    end
    if (!a_if.Dac_cs_n && p_cs_a) begin
      cs_falls_a++;
      gap_a        = cyc - ldacrise_cyc_a;
      csfall_cyc_a = cyc;
      bits_a       = 0;
      cs_low_a     = 0;
    end
    if (!a_if.Dac_cs_n) cs_low_a++;
    if (a_if.Dac_sclk && !p_sclk_a) begin
      shr_a = {shr_a[14:0], a_if.Dac_sdi};
      bits_a++;
      if (bits_a == 1) rise1_cyc_a = cyc;
    end
    if (a_if.Dac_sclk && (a_if.Dac_sdi !== p_sdi_a)) sdi_viol_a++;
    if (a_if.Dac_cs_n && !p_cs_a && mon_en) begin
      chk("a_bits", bits_a, 16);
      chk("a_cs_low_len", cs_low_a, 33 * DIV);
      chk("a_first_rise", rise1_cyc_a - csfall_cyc_a, 2 * DIV);
      if (sb_a.size() == 0) chk("a_unexpected_frame", shr_a, 32'hDEAD);
      else chk("a_frame", shr_a, sb_a.pop_front());
    end
    if (a_if.Overrun) begin
      ovr_pulses_a++;
      ovr_cyc_a = cyc;
    end
    p_sclk_a = a_if.Dac_sclk;
    p_cs_a   = a_if.Dac_cs_n;
    p_ldac_a = a_if.Dac_ldac_n;
    p_sdi_a  = a_if.Dac_sdi;
  end

  // Monitor, CLK_DIV=1 instance
  logic [15:0] shr_b = '0;
  logic p_sclk_b = 1'b0, p_cs_b = 1'b1, p_ldac_b = 1'b1, p_sdi_b = 1'b0;
  int bits_b = 0, csfall_cyc_b = 0, frames_b = 0, sdi_viol_b = 0;

  always @(negedge clk) begin
    if (b_if.Dac_ldac_n && !p_ldac_b) begin
      frames_b++;
      chk("b_frame_latency", cyc - csfall_cyc_b, 35);
    end
    if (!b_if.Dac_cs_n && p_cs_b) begin
      csfall_cyc_b = cyc;
      bits_b       = 0;
    end
    if (b_if.Dac_sclk && !p_sclk_b) begin
      shr_b = {shr_b[14:0], b_if.Dac_sdi};
      bits_b++;
    end
    if (b_if.Dac_sclk && (b_if.Dac_sdi !== p_sdi_b)) sdi_viol_b++;
    if (b_if.Dac_cs_n && !p_cs_b) begin
      chk("b_bits", bits_b, 16);
      if (sb_b.size() == 0) chk("b_unexpected_frame", shr_b, 32'hDEAD);
      else chk("b_frame", shr_b, sb_b.pop_front());
    end
    p_sclk_b = b_if.Dac_sclk;
    p_cs_b   = b_if.Dac_cs_n;
    p_ldac_b = b_if.Dac_ldac_n;
    p_sdi_b  = b_if.Dac_sdi;
  end

  int stb_cyc_a = 0;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe_a(input logic [11:0] d, input bit exp_acc);
    @(negedge clk);
    a_if.Sample_stb  = 1'b1;
    a_if.Sample_data = d;
    if (exp_acc) sb_a.push_back(frame_of(d));
    @(negedge clk);
    a_if.Sample_stb = 1'b0;
    stb_cyc_a = cyc;
  endtask

  task automatic strobe_b(input logic [11:0] d);
    @(negedge clk);
    b_if.Sample_stb  = 1'b1;
    b_if.Sample_data = d;
    sb_b.push_back(frame_of(d));
    @(negedge clk);
    b_if.Sample_stb = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget);
    int k = 0;
    while ((a_if.Busy || (mon_en && sb_a.size() != 0)) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) chk("a_idle_timeout", 1, 0);
    wait_cyc(2);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    a_if.Sample_stb = 1'b0;
    a_if.Hlt = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    sb_a.delete();
    wait_cyc(2);
    mon_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, o0, f0, s3, k;
    a_if.Hlt = 1'b0; a_if.Sample_stb = 1'b0; a_if.Sample_data = '0;
    b_if.Hlt = 1'b0; b_if.Sample_stb = 1'b0; b_if.Sample_data = '0;
    wait_cyc(3);
    chk("rst_cs_n", a_if.Dac_cs_n, 1);
    chk("rst_sclk", a_if.Dac_sclk, 0);
    chk("rst_sdi", a_if.Dac_sdi, 0);
    chk("rst_ldac_n", a_if.Dac_ldac_n, 1);
    chk("rst_busy", a_if.Busy, 0);
    chk("rst_overrun", a_if.Overrun, 0);
    chk("rst_drop_cnt", a_if.Drop_cnt, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    wait_cyc(2);

    // Single frame of mid-scale zero
    p0 = ldac_pulses_a;
    strobe_a(12'h000, 1);
    wait_idle_a(400);
    chk("t1_setup_latency", csfall_cyc_a - stb_cyc_a, 0);
    chk("t1_ldac_pulses", ldac_pulses_a - p0, 1);
    chk("t1_busy_low", a_if.Busy, 0);

    // Second strobe lands in the holding slot and follows without an idle gap
    o0 = ovr_pulses_a;
    strobe_a(12'h7FF, 1);
    wait_cyc(48);
    strobe_a(12'h800, 1);
    wait_idle_a(600);
    chk("t2_no_gap", gap_a, 0);
    chk("t2_overrun", ovr_pulses_a - o0, 0);
    chk("t2_drop_cnt", a_if.Drop_cnt, 0);

    // One in flight, one held, third dropped
    o0 = ovr_pulses_a;
    strobe_a(12'h123, 1);
    wait_cyc(8);
    strobe_a(12'h456, 1);
    wait_cyc(8);
    strobe_a(12'h789, 0);
    s3 = stb_cyc_a;
    wait_cyc(2);
    chk("t3_overrun_cycle", ovr_cyc_a - s3, 0);
    wait_idle_a(600);
    chk("t3_overrun_pulses", ovr_pulses_a - o0, 1);
    chk("t3_drop_cnt", a_if.Drop_cnt, 1);

    // Halt masks strobes; halting mid-frame lets the frame finish
    do_reset();
    f0 = cs_falls_a;
    a_if.Hlt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      strobe_a(12'h100 + 12'(i), 0);
      wait_cyc(3);
    end
    wait_cyc(20);
    chk("t4_no_cs_activity", cs_falls_a - f0, 0);
    chk("t4_drop_cnt", a_if.Drop_cnt, 0);
    a_if.Hlt = 1'b0;
    p0 = ldac_pulses_a;
    strobe_a(12'h5A5, 1);
    wait_cyc(30);
    a_if.Hlt = 1'b1;
    wait_idle_a(400);
    chk("t4_halt_frame_ldac", ldac_pulses_a - p0, 1);
    a_if.Hlt = 1'b0;

    // Reset at the 8th sclk rise aborts the frame without LDAC
    strobe_a(12'h3C3, 1);
    k = 0;
    while (bits_a < 8 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) chk("t5_sclk_timeout", 1, 0);
    mon_en = 1'b0;
    p0 = ldac_pulses_a;
    rst_n = 1'b0;
    #1;
    chk("t5_abort_cs_n", a_if.Dac_cs_n, 1);
    chk("t5_abort_sclk", a_if.Dac_sclk, 0);
    sb_a.delete();
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(50);
    chk("t5_no_ldac", ldac_pulses_a - p0, 0);
    mon_en = 1'b1;
    strobe_a(12'h0F0, 1);
    wait_idle_a(400);
    chk("t5_recover_ldac", ldac_pulses_a - p0, 1);

    // Saturating drop counter
    do_reset();
    mon_en = 1'b0;
    f0 = ldac_pulses_a;
    o0 = ovr_pulses_a;
    for (int i = 0; i < 300; i++) begin
      strobe_a(12'(i), 0);
      wait_cyc(8);
    end
    wait_idle_a(1000);
    chk("t6_drop_saturate", a_if.Drop_cnt, 255);
    chk("t6_sent_plus_dropped", (ovr_pulses_a - o0) + (ldac_pulses_a - f0), 300);
    for (int i = 0; i < 3; i++) strobe_a(12'hABC, 0);
    wait_idle_a(1000);
    chk("t6_drop_holds", a_if.Drop_cnt, 255);
    mon_en = 1'b1;

    // CLK_DIV=1 smoke run
    f0 = frames_b;
    strobe_b(12'h000);
    wait_cyc(40);
    strobe_b(12'hABC);
    wait_cyc(40);
    strobe_b(12'h7FF);
    k = 0;
    while ((frames_b - f0 < 3) && k < 200) begin
      @(negedge clk);
      k++;
    end
    wait_cyc(3);
    chk("b_frames", frames_b - f0, 3);
    chk("b_sdi_stable", sdi_viol_b, 0);
    chk("a_sdi_stable", sdi_viol_a, 0);
    chk("a_sb_drained", sb_a.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
